// File: rtl/layer_input_buffer_if.sv
// Upstream word stream into the layer input buffer.
// valid/ready handshake carrying one signed word per transfer.
interface layer_input_buffer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                         in_valid;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic                         in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/layer_input_buffer.sv
// Assembles NUM_INPUTS words into a vector and hands it to a neuron.
// Optional prefetch bank: define LAYER_INPUT_BUFFER_PREFETCH_EN.
module layer_input_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUTS = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    layer_input_buffer_if.slave          up,
    output logic signed [DATA_WIDTH-1:0] inputs [NUM_INPUTS],
    output logic                         input_ready,
    input  logic                         output_ready,
    output logic                         busy
);
    localparam int CW = $clog2(NUM_INPUTS) + 1;
    localparam int IW = $clog2(NUM_INPUTS);
    localparam logic [CW-1:0] LAST = CW'(NUM_INPUTS - 1);

    typedef enum logic [1:0] {
        FILLING   = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] count;
    logic          accept;

    assign accept = up.in_valid && up.in_ready;

`ifdef LAYER_INPUT_BUFFER_PREFETCH_EN
    localparam logic [CW-1:0] FULL = CW'(NUM_INPUTS);

    logic signed [DATA_WIDTH-1:0] back [NUM_INPUTS];
    logic [CW-1:0]                back_count;
    logic                         release_v;
    logic [CW-1:0]                xfer_count;

    assign release_v  = (state == WAIT_DONE) && output_ready;
    assign xfer_count = back_count + CW'(accept);
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= FILLING;
        else       state <= state_nx;
    end

    // Next-state selection
    always_comb begin
        state_nx = FILLING;
        case (state)
            FILLING: begin
                if (accept && count == LAST) state_nx = ISSUE;
                else                         state_nx = FILLING;
            end
            ISSUE: state_nx = WAIT_DONE;
            WAIT_DONE: begin
`ifdef LAYER_INPUT_BUFFER_PREFETCH_EN
                if (release_v)
                    state_nx = (xfer_count == FULL) ? ISSUE : FILLING;
                else
                    state_nx = WAIT_DONE;
`else
                state_nx = output_ready ? FILLING : WAIT_DONE;
`endif
            end
            default: state_nx = FILLING;
        endcase
    end

    // Moore outputs: ready, issue strobe, busy
    always_comb begin
        up.in_ready = 1'b0;
        input_ready = 1'b0;
        case (state)
            FILLING: up.in_ready = 1'b1;
            ISSUE: begin
                input_ready = 1'b1;
`ifdef LAYER_INPUT_BUFFER_PREFETCH_EN
                up.in_ready = (back_count < FULL);
`endif
            end
            WAIT_DONE: begin
`ifdef LAYER_INPUT_BUFFER_PREFETCH_EN
                up.in_ready = (back_count < FULL);
`endif
            end
            default: up.in_ready = 1'b0;
        endcase
        busy = (state != FILLING) || (count != '0);
    end

    // Vector banks and fill counters
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) inputs[i] <= '0;
`ifdef LAYER_INPUT_BUFFER_PREFETCH_EN
            back_count <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) back[i] <= '0;
`endif
        end else begin
            case (state)
                FILLING: begin
                    if (accept) begin
                        inputs[count[IW-1:0]] <= up.in_data;
                        count <= (count == LAST) ? '0 : count + 1'b1;
                    end
                end
                ISSUE, WAIT_DONE: begin
`ifdef LAYER_INPUT_BUFFER_PREFETCH_EN
                    // Release swaps the prefetched words in; a word
                    // arriving on the same cycle extends the front bank.
                    if (release_v) begin
                        for (int i = 0; i < NUM_INPUTS; i++)
                            inputs[i] <= back[i];
                        if (accept)
                            inputs[back_count[IW-1:0]] <= up.in_data;
                        count <= (xfer_count == FULL) ? '0 : xfer_count;
                        back_count <= '0;
                    end else if (accept) begin
                        back[back_count[IW-1:0]] <= up.in_data;
                        back_count <= back_count + 1'b1;
                    end
`endif
                end
                default: count <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_input_buffer.sv
// Directed and random checks of layer_input_buffer against a
// queue-free behavioural model of the fill/issue/release rules.
module tb_layer_input_buffer;
    localparam int N  = 4;
    localparam int DW = 32;
`ifdef LAYER_INPUT_BUFFER_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic clock;
    logic reset;
    logic output_ready;
    logic input_ready;
    logic busy;
    logic signed [DW-1:0] inputs [N];

    layer_input_buffer_if #(.DATA_WIDTH(DW)) bus ();

    layer_input_buffer #(
        .DATA_WIDTH (DW),
        .NUM_INPUTS (N)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .up           (bus.slave),
        .inputs       (inputs),
        .input_ready  (input_ready),
        .output_ready (output_ready),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // model: 0 filling, 1 issuing, 2 waiting for release
    int phase;
    int front_n;
    int back_n;
    logic signed [DW-1:0] mvec  [N];
    logic signed [DW-1:0] mback [N];

    task automatic chk(input string tag,
                       input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit m_ready();
        if (phase == 0) return 1'b1;
        return PF && (back_n < N);
    endfunction

    task automatic model_reset();
        phase = 0;
        front_n = 0;
        back_n = 0;
        for (int i = 0; i < N; i++) begin
            mvec[i] = '0;
            mback[i] = '0;
        end
    endtask

    task automatic model(input bit v, input logic signed [DW-1:0] d,
                         input bit o, output bit acc);
        acc = v && m_ready();
        case (phase)
            0: if (acc) begin
                mvec[front_n] = d;
                front_n++;
                if (front_n == N) begin
                    front_n = 0;
                    phase = 1;
                end
            end
            1: begin
                if (acc) begin
                    mback[back_n] = d;
                    back_n++;
                end
                phase = 2;
            end
            default: begin
                if (o) begin
                    if (PF) begin
                        mvec = mback;
                        if (acc) mvec[back_n] = d;
                        front_n = back_n + int'(acc);
                        back_n = 0;
                        if (front_n == N) begin
                            front_n = 0;
                            phase = 1;
                        end else begin
                            phase = 0;
                        end
                    end else begin
                        phase = 0;
                    end
                end else if (acc) begin
                    mback[back_n] = d;
                    back_n++;
                end
            end
        endcase
    endtask

    task automatic check_vec();
        for (int i = 0; i < N; i++)
            chk($sformatf("inputs[%0d]", i), inputs[i], mvec[i]);
    endtask

    task automatic step(input bit v, input logic signed [DW-1:0] d,
                        input bit o, output bit acc);
        bus.in_valid = v;
        bus.in_data  = d;
        output_ready = o;
        #3;
        chk("in_ready", bus.in_ready, m_ready());
        chk("input_ready", input_ready, phase == 1);
        chk("busy", busy, (phase != 0) || (front_n != 0));
        model(v, d, o, acc);
        @(posedge clock);
        #1;
        check_vec();
    endtask

    task automatic do_reset(input bit v, input bit o);
        reset = 1'b1;
        bus.in_valid = v;
        bus.in_data  = 32'sd99;
        output_ready = o;
        @(posedge clock);
        #1;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        output_ready = 1'b0;
        model_reset();
        check_vec();
    endtask

    task automatic push(input int base, input int n, input int budget,
                        output int got);
        bit acc;
        got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            step(1'b1, base + got, 1'b0, acc);
            if (acc) got++;
        end
    endtask

    initial begin
        bit acc;
        int got;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        output_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        do_reset(1'b1, 1'b1);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_strobe", input_ready, 0);

        // basic fill 1..4
        push(1, 4, 4, got);
        chk("fill_accepts", got, 4);
        chk("fill_strobe", input_ready, 1);
        for (int i = 0; i < N; i++)
            chk("fill_vec", inputs[i], i + 1);
        step(1'b0, 0, 1'b0, acc);
        step(1'b0, 0, 1'b0, acc);
        chk("wait_busy", busy, 1);
        step(1'b0, 0, 1'b1, acc);

        // gapped stream -5,7,-9,11
        step(1'b1, -5, 1'b0, acc);
        step(1'b0, 0, 1'b0, acc);
        step(1'b1, 7, 1'b0, acc);
        step(1'b0, 0, 1'b0, acc);
        step(1'b1, -9, 1'b0, acc);
        step(1'b0, 0, 1'b0, acc);
        step(1'b1, 11, 1'b0, acc);
        chk("gap_strobe", input_ready, 1);
        chk("gap_v0", inputs[0], -5);
        chk("gap_v3", inputs[3], 11);

        // 20 held cycles in WAIT_DONE
        for (int i = 0; i < 20; i++)
            step(PF ? 1'b0 : 1'($urandom_range(0, 1)),
                 $urandom, 1'b0, acc);
        chk("hold_v1", inputs[1], 7);
        step(1'b0, 0, 1'b1, acc);
        // stray release while filling
        step(1'b0, 0, 1'b1, acc);
        step(1'b0, 0, 1'b1, acc);
        chk("stray_busy", busy, 0);

        // reset after two words
        push(40, 2, 2, got);
        chk("part_busy", busy, 1);
        do_reset(1'b1, 1'b0);
        chk("part_rst_v0", inputs[0], 0);
        chk("part_rst_busy", busy, 0);
        push(31, 4, 4, got);
        chk("refill_v0", inputs[0], 31);
        chk("refill_v3", inputs[3], 34);
        step(1'b0, 0, 1'b0, acc);
        do_reset(1'b0, 1'b1);

        // prefetch scenario 10..13 then 20..23
        push(10, 4, 4, got);
        push(20, 4, 6, got);
        chk("pre_accepts", got, PF ? 4 : 0);
        chk("pre_in_ready", bus.in_ready, 0);
        chk("pre_held_v0", inputs[0], 10);
        step(1'b1, 20 + got, 1'b1, acc);
        if (PF) begin
            chk("pre_issue", input_ready, 1);
            chk("pre_v0", inputs[0], 20);
            chk("pre_v3", inputs[3], 23);
            step(1'b0, 0, 1'b0, acc);
            step(1'b0, 0, 1'b1, acc);
        end else begin
            push(20, 4, 4, got);
            chk("late_accepts", got, 4);
            chk("late_v0", inputs[0], 20);
            chk("late_v3", inputs[3], 23);
            step(1'b0, 0, 1'b1, acc);
        end

        // random traffic against the model
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset(1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
            end else begin
                step(1'($urandom_range(0, 1)), $urandom,
                     $urandom_range(0, 3) == 0, acc);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
